// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg -- shared defaults and types for the ram block.
//
// Contents:
//   DATA_W  default word width in bits
//   ADDR_W  default address width in bits
//   DEPTH   number of words (2**ADDR_W)
//   word_t  one memory word at the default width
//   addr_t  one address at the default width
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram_pkg

// File: rtl/ram_array.sv
// ----------------------------------------------------------------------------
// ram_array -- storage and synchronous write port of the ram block.
//
// The array itself has no reset: contents survive a reset of the surrounding
// block. The read side is an asynchronous look-up of the current contents; the
// parent registers it, which gives read-first behaviour on a same-address
// read/write collision (the look-up sees the pre-edge word).
//
// Ports:
//   clk_i    clock, writes happen on its rising edge
//   we_i     write enable (already qualified by the parent)
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  word currently stored at raddr_i
// ----------------------------------------------------------------------------
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter int ADDR_W = ram_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : ram_array

// File: rtl/ram.sv
// ----------------------------------------------------------------------------
// ram -- simple dual-port RAM, one write port and one registered read port.
//
// Read latency is one cycle: the address present at a rising edge selects the
// word shown on ram_r_data after that edge. Reset clears only the read
// register and blocks writes; memory contents are kept across reset.
//
// Build option:
//   RAM_BYPASS_EN  defined   -> same-address read/write returns the new data
//                  undefined -> same-address read/write returns the old data
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   ram_w_en    write enable
//   ram_w_addr  write address
//   ram_w_data  write data
//   ram_r_addr  read address, sampled every edge
//   ram_r_data  registered read data
// ----------------------------------------------------------------------------
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter int ADDR_W = ram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_w_en,
    input  logic [ADDR_W-1:0] ram_w_addr,
    input  logic [DATA_W-1:0] ram_w_data,
    input  logic [ADDR_W-1:0] ram_r_addr,
    output logic [DATA_W-1:0] ram_r_data
);

    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Writes are suppressed while reset is asserted.
    assign arr_we = ram_w_en & ~rst;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .waddr_i (ram_w_addr),
        .wdata_i (ram_w_data),
        .raddr_i (ram_r_addr),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        rd_data_d = arr_rdata;
`ifdef RAM_BYPASS_EN
        // Write-first: forward the incoming word on an address collision.
        if (ram_w_en && (ram_w_addr == ram_r_addr)) begin
            rd_data_d = ram_w_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign ram_r_data = rd_data_q;

endmodule : ram

// File: tb/tb_ram.sv
module tb_ram;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: only words that were really written are known
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q [$];
  bit            exp_known;
  logic [DW-1:0] exp_data;

  ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model,
  // check just after the edge, disturb inputs, check again before next edge.
  task automatic cyc(input string tag, input bit r, input bit we,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [AW-1:0] ra);
    bit bypass;
    rst        = r;
    ram_w_en   = we;
    ram_w_addr = wa;
    ram_w_data = wd;
    ram_r_addr = ra;
    @(posedge clk);
`ifdef RAM_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    if (r) begin
      exp_known = 1'b1;
      exp_data  = '0;
    end else if (bypass && we && (wa == ra)) begin
      exp_known = 1'b1;
      exp_data  = wd;
    end else if (ref_mem.exists(int'(ra))) begin
      exp_known = 1'b1;
      exp_data  = ref_mem[int'(ra)];
    end else begin
      exp_known = 1'b0;
    end
    if (!r && we) ref_mem[int'(wa)] = wd;
    if (exp_known) exp_q.push_back(exp_data);
    #1;
    if (exp_known) check(tag, ram_r_data, exp_q[$]);
    // inputs wander between edges; output must not follow
    ram_r_addr = AW'($urandom_range(0, 255));
    ram_w_data = DW'($urandom);
    #3;
    if (exp_known) check({tag, "_hold"}, ram_r_data, exp_q[$]);
  endtask

  initial begin
    rst = 1'b1; ram_w_en = 1'b0; ram_w_addr = '0; ram_w_data = '0; ram_r_addr = '0;
    @(negedge clk);

    // reset with write enable active: output 0, write to 211 dropped
    cyc("rst_a", 1, 1, 8'd211, 16'hFFFF, 8'd211);
    cyc("rst_b", 1, 1, 8'd211, 16'hFFFF, 8'd211);

    // basic writes and reads
    cyc("wr_dead", 0, 1, 8'd211, 16'hDEAD, 8'd211);
    cyc("wr_beef", 0, 1, 8'd201, 16'hBEEF, 8'd211);
    cyc("rd_201",  0, 0, 8'd0,   16'h0,    8'd201);

    // back-to-back reads
    cyc("b2b_211", 0, 0, 8'd0, 16'h0, 8'd211);
    cyc("b2b_201", 0, 0, 8'd0, 16'h0, 8'd201);
    cyc("b2b_211b",0, 0, 8'd0, 16'h0, 8'd211);

    // same-address collision, then plain re-read
    cyc("coll_211", 0, 1, 8'd211, 16'h1234, 8'd211);
    cyc("after_coll", 0, 0, 8'd0, 16'h0, 8'd211);

    // mid-sequence reset with a write attempt to 201
    cyc("rst_mid", 1, 1, 8'd201, 16'h0BAD, 8'd201);
    cyc("post_rst_201", 0, 0, 8'd0, 16'h0, 8'd201);
    cyc("post_rst_211", 0, 0, 8'd0, 16'h0, 8'd211);

    // address extremes, no aliasing
    cyc("wr_0",   0, 1, 8'd0,   16'h0001, 8'd201);
    cyc("wr_255", 0, 1, 8'd255, 16'hFFFF, 8'd0);
    cyc("rd_255", 0, 0, 8'd0,   16'h0,    8'd255);
    cyc("rd_211", 0, 0, 8'd0,   16'h0,    8'd211);
    cyc("rd_201", 0, 0, 8'd0,   16'h0,    8'd201);
    cyc("rd_0",   0, 0, 8'd0,   16'h0,    8'd0);

    // different-address simultaneous read/write
    cyc("rw_diff", 0, 1, 8'd5, 16'hA5A5, 8'd255);
    cyc("rd_5",    0, 0, 8'd0, 16'h0,    8'd5);

    // random traffic over a narrow address window to force collisions
    for (int i = 0; i < 300; i++) begin
      cyc("rand",
          ($urandom_range(0, 19) == 0),
          $urandom_range(0, 1) == 1,
          AW'($urandom_range(0, 15)),
          DW'($urandom),
          AW'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_ram
